// File: rtl/elevator_pkg.sv
// Shared types and helpers for the collective-control elevator scheduler.
package elevator_pkg;

  localparam int MAX_FLOORS  = 16;
  localparam int FLOOR_IDX_W = $clog2(MAX_FLOORS);
  localparam int DIST_W      = FLOOR_IDX_W + 1;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  function automatic logic [DIST_W-1:0] floor_dist(input logic [FLOOR_IDX_W-1:0] a,
                                                   input logic [FLOOR_IDX_W-1:0] b);
    if (a >= b) return {1'b0, a - b};
    else        return {1'b0, b - a};
  endfunction

endpackage

// File: rtl/elevator_scheduler_floor_search.sv
// Nearest pending request above/below the cabin, plus the request at the cabin floor.
module floor_search
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 3,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] led_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  above_v_o,
  output logic [FLOOR_W-1:0]    above_f_o,
  output logic                  below_v_o,
  output logic [FLOOR_W-1:0]    below_f_o,
  output logic                  here_o
);

  // Ascending scan: first hit above is the lowest, last hit below is the highest.
  always_comb begin
    above_v_o = 1'b0;
    above_f_o = '0;
    below_v_o = 1'b0;
    below_f_o = '0;
    here_o    = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (led_i[i] && (i > 32'(floor_i)) && !above_v_o) begin
        above_v_o = 1'b1;
        above_f_o = FLOOR_W'(i);
      end
      if (led_i[i] && (i < 32'(floor_i))) begin
        below_v_o = 1'b1;
        below_f_o = FLOOR_W'(i);
      end
    end
    if (32'(floor_i) < NUM_FLOORS) here_o = led_i[floor_i];
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Request latch, IDLE/UP/DOWN collective-control FSM and registered goal floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 3,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS),
  parameter int TIE_DOWN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  move_handler,
  input  logic                  arrived,
  output logic [NUM_FLOORS-1:0] led,
  output logic [FLOOR_W-1:0]    gf,
  output logic [1:0]            dir,
  output logic                  floor_err
);

  logic [NUM_FLOORS-1:0] led_q, led_d;
  logic [FLOOR_W-1:0]    gf_q, gf_d;
  dir_e                  dir_q, dir_d;
  logic                  err_q, err_d;

  logic [NUM_FLOORS-1:0] clr;
  logic                  floor_ok;
  logic                  above_v, below_v, here;
  logic [FLOOR_W-1:0]    above_f, below_f;
  logic [DIST_W-1:0]     d_up, d_dn;
  logic                  pick_up;

  floor_search #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_search (
    .led_i     (led_q),
    .floor_i   (floor),
    .above_v_o (above_v),
    .above_f_o (above_f),
    .below_v_o (below_v),
    .below_f_o (below_f),
    .here_o    (here)
  );

  assign floor_ok = (32'(floor) < NUM_FLOORS);

  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      clr[i] = arrived && (32'(floor) == i);
    end
  end

  assign d_up    = floor_dist(FLOOR_IDX_W'(above_f), FLOOR_IDX_W'(floor));
  assign d_dn    = floor_dist(FLOOR_IDX_W'(floor), FLOOR_IDX_W'(below_f));
  assign pick_up = (d_up < d_dn) || ((d_up == d_dn) && (TIE_DOWN == 0));

  always_comb begin
    led_d = led_q;
    gf_d  = gf_q;
    dir_d = dir_q;
    err_d = 1'b0;
    if (!floor_ok) begin
      // Invalid position: park the goal and freeze the request set.
      err_d = 1'b1;
      gf_d  = '0;
      dir_d = DIR_IDLE;
    end else begin
      led_d = (led_q | call_req) & ~clr;
      if (!move_handler) begin
        if (here) begin
          gf_d = floor;
        end else begin
          case (dir_q)
            DIR_UP: begin
              if (above_v) begin
                gf_d = above_f;
              end else if (below_v) begin
                gf_d  = below_f;
                dir_d = DIR_DOWN;
              end else begin
                gf_d  = floor;
                dir_d = DIR_IDLE;
              end
            end
            DIR_DOWN: begin
              if (below_v) begin
                gf_d = below_f;
              end else if (above_v) begin
                gf_d  = above_f;
                dir_d = DIR_UP;
              end else begin
                gf_d  = floor;
                dir_d = DIR_IDLE;
              end
            end
            default: begin
              if (above_v && (!below_v || pick_up)) begin
                gf_d  = above_f;
                dir_d = DIR_UP;
              end else if (below_v) begin
                gf_d  = below_f;
                dir_d = DIR_DOWN;
              end else begin
                gf_d  = floor;
                dir_d = DIR_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      gf_q  <= '0;
      dir_q <= DIR_IDLE;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      gf_q  <= gf_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end

  assign led       = led_q;
  assign gf        = gf_q;
  assign dir       = dir_q;
  assign floor_err = err_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomised bench for elevator_scheduler against a distance-based reference model.
module tb_elevator_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 3 floors, ties go down
  logic [2:0] a_req, a_led;
  logic [1:0] a_fl, a_gf, a_dir;
  logic       a_mv, a_arr, a_err;
  // DUT B: 5 floors, ties go up
  logic [4:0] b_req, b_led;
  logic [2:0] b_fl, b_gf;
  logic [1:0] b_dir;
  logic       b_mv, b_arr, b_err;

  elevator_scheduler #(.NUM_FLOORS(3), .TIE_DOWN(1)) dut_a (
    .clk(clk), .rst(rst), .call_req(a_req), .floor(a_fl), .move_handler(a_mv),
    .arrived(a_arr), .led(a_led), .gf(a_gf), .dir(a_dir), .floor_err(a_err)
  );

  elevator_scheduler #(.NUM_FLOORS(5), .TIE_DOWN(0)) dut_b (
    .clk(clk), .rst(rst), .call_req(b_req), .floor(b_fl), .move_handler(b_mv),
    .arrived(b_arr), .led(b_led), .gf(b_gf), .dir(b_dir), .floor_err(b_err)
  );

  typedef struct {
    logic [15:0] led;
    int          gf;
    int          dir;   // 0 idle, 1 up, 2 down
    bit          err;
  } mstate_t;

  mstate_t ma, mb;
  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: nearest request measured as a floor offset k, then collective-control rules.
  function automatic mstate_t step_model(mstate_t s, int nf, bit tie_down, bit r,
                                         logic [15:0] req, int fl, bit mv, bit arr);
    mstate_t n;
    int up_k, dn_k;
    n = s;
    if (r) begin
      n.led = '0; n.gf = 0; n.dir = 0; n.err = 1'b0;
      return n;
    end
    if (fl >= nf) begin
      n.err = 1'b1; n.gf = 0; n.dir = 0;
      return n;
    end
    n.err = 1'b0;
    for (int f = 0; f < nf; f++) if (req[f]) n.led[f] = 1'b1;
    if (arr) n.led[fl] = 1'b0;
    if (mv) return n;
    up_k = 0;
    dn_k = 0;
    for (int k = nf - 1; k >= 1; k--) begin
      if (fl + k < nf && s.led[fl + k]) up_k = k;
      if (fl - k >= 0 && s.led[fl - k]) dn_k = k;
    end
    if (s.led[fl]) begin
      n.gf = fl;
    end else if (s.dir == 1) begin
      if (up_k > 0)      n.gf = fl + up_k;
      else if (dn_k > 0) begin n.gf = fl - dn_k; n.dir = 2; end
      else               begin n.gf = fl; n.dir = 0; end
    end else if (s.dir == 2) begin
      if (dn_k > 0)      n.gf = fl - dn_k;
      else if (up_k > 0) begin n.gf = fl + up_k; n.dir = 1; end
      else               begin n.gf = fl; n.dir = 0; end
    end else begin
      if (up_k > 0 && dn_k > 0) begin
        if (up_k < dn_k || (up_k == dn_k && !tie_down)) begin n.gf = fl + up_k; n.dir = 1; end
        else                                            begin n.gf = fl - dn_k; n.dir = 2; end
      end else if (up_k > 0) begin n.gf = fl + up_k; n.dir = 1; end
      else if (dn_k > 0)     begin n.gf = fl - dn_k; n.dir = 2; end
      else                   n.gf = fl;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step_model(ma, 3, 1'b1, rst, {13'b0, a_req}, int'(a_fl), a_mv, a_arr);
    mb = step_model(mb, 5, 1'b0, rst, {11'b0, b_req}, int'(b_fl), b_mv, b_arr);
  end

  always @(negedge clk) begin
    if (checking) begin
      check("a_led", 32'(a_led), 32'(ma.led[2:0]));
      check("a_gf",  32'(a_gf),  32'(ma.gf));
      check("a_dir", 32'(a_dir), 32'(ma.dir));
      check("a_err", 32'(a_err), 32'(ma.err));
      check("b_led", 32'(b_led), 32'(mb.led[4:0]));
      check("b_gf",  32'(b_gf),  32'(mb.gf));
      check("b_dir", 32'(b_dir), 32'(mb.dir));
      check("b_err", 32'(b_err), 32'(mb.err));
    end
  end

  initial begin
    rst = 1'b1;
    a_req = '0; a_fl = '0; a_mv = 1'b0; a_arr = 1'b0;
    b_req = '0; b_fl = '0; b_mv = 1'b0; b_arr = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("reset_led", 32'(a_led), 32'd0);
    check("reset_gf",  32'(a_gf),  32'd0);
    check("reset_dir", 32'(a_dir), 32'd0);
    check("reset_err", 32'(a_err), 32'd0);
    rst = 1'b0;

    // Requests at floors 1 and 2 from floor 0
    a_req = 3'b110;
    @(negedge clk);
    check("t1_led", 32'(a_led), 32'b110);
    a_req = '0;
    @(negedge clk);
    check("t1_gf",  32'(a_gf),  32'd1);
    check("t1_dir", 32'(a_dir), 32'd1);

    // Goal frozen while moving; arrival at 1 continues upward
    a_mv = 1'b1; a_req = 3'b001;
    @(negedge clk);
    a_req = '0;
    check("t2_led", 32'(a_led), 32'b111);
    check("t2_gf_frozen", 32'(a_gf), 32'd1);
    a_fl = 2'd1; a_mv = 1'b0; a_arr = 1'b1;
    @(negedge clk);
    check("t2_led_clr", 32'(a_led), 32'b101);
    a_arr = 1'b0;
    @(negedge clk);
    check("t2_gf", 32'(a_gf), 32'd2);
    check("t2_dir", 32'(a_dir), 32'd1);

    // Set and clear on the same floor: clear wins
    a_req = 3'b010; a_arr = 1'b1;
    @(negedge clk);
    check("t4_led", 32'(a_led), 32'b101);
    a_req = '0; a_arr = 1'b0;

    // Out-of-range floor
    a_fl = 2'd3;
    @(negedge clk);
    check("t5_err", 32'(a_err), 32'd1);
    check("t5_gf",  32'(a_gf),  32'd0);
    check("t5_dir", 32'(a_dir), 32'd0);
    check("t5_led", 32'(a_led), 32'b101);
    a_fl = 2'd2;
    @(negedge clk);
    check("t5_err_drop", 32'(a_err), 32'd0);

    // Build led=111 with dir=DOWN, then reset
    a_arr = 1'b1;
    @(negedge clk);
    a_arr = 1'b0;
    @(negedge clk);
    a_mv = 1'b1; a_req = 3'b110;
    @(negedge clk);
    a_req = '0;
    @(negedge clk);
    check("t6_led_pre", 32'(a_led), 32'b111);
    check("t6_dir_pre", 32'(a_dir), 32'd2);
    rst = 1'b1;
    #1;
    check("t6_no_edge_led", 32'(a_led), 32'b111);
    check("t6_no_edge_dir", 32'(a_dir), 32'd2);
    @(negedge clk);
    check("t6_led", 32'(a_led), 32'd0);
    check("t6_gf",  32'(a_gf),  32'd0);
    check("t6_dir", 32'(a_dir), 32'd0);
    check("t6_err", 32'(a_err), 32'd0);
    rst = 1'b0; a_mv = 1'b0;

    // Equidistant requests from IDLE: A breaks down, B breaks up
    a_fl = 2'd1; a_req = 3'b101;
    b_fl = 3'd2; b_req = 5'b10001;
    @(negedge clk);
    a_req = '0; b_req = '0;
    @(negedge clk);
    check("t3_a_gf",  32'(a_gf),  32'd0);
    check("t3_a_dir", 32'(a_dir), 32'd2);
    check("t3_b_gf",  32'(b_gf),  32'd4);
    check("t3_b_dir", 32'(b_dir), 32'd1);

    repeat (3000) begin
      rst   = ($urandom_range(0, 299) == 0);
      a_req = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      a_fl  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a_mv  = ($urandom_range(0, 2) == 0);
      a_arr = ($urandom_range(0, 3) == 0);
      b_req = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
      b_fl  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      b_mv  = ($urandom_range(0, 2) == 0);
      b_arr = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
